// File: rtl/hs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hs_pkg
// Purpose  : Shared constants and types for the hard-swish output packer.
//            c_ACT_WIDTH / c_LANES are the default activation width and
//            lanes per packed word. c_WORD_WIDTH is the resulting packed-word
//            width. hs_state_t is the frame-control state encoding.
// Revision : 1.0  initial release
// ============================================================================
package hs_pkg;

    localparam int c_ACT_WIDTH  = 14;
    localparam int c_LANES      = 4;
    localparam int c_WORD_WIDTH = c_ACT_WIDTH * c_LANES;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PACK  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } hs_state_t;

endpackage : hs_pkg
`default_nettype wire

// File: rtl/hs_word_fifo.sv
`default_nettype none
// ============================================================================
// Module   : hs_word_fifo
// Purpose  : Small synchronous FIFO for packed words. A push into a full FIFO
//            is accepted only when a pop happens in the same cycle.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            push/push_data - write request and data
//            pop           - read request (ignored while empty)
//            head          - oldest entry (undefined while empty)
//            full / empty  - occupancy flags
// Revision : 1.0  initial release
// ============================================================================
module hs_word_fifo #(
    parameter int WIDTH = 56,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

    assign w_do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a full FIFO can still take a push.
    assign w_do_push = push && (!full || w_do_pop);

    assign head = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Storage needs no reset: contents are only visible through valid pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
        end
    end

endmodule : hs_word_fifo
`default_nettype wire

// File: rtl/hs_out_packer.sv
`default_nettype none
// ============================================================================
// Module   : hs_out_packer
// Purpose  : Consumer end of the hard-swish activation stream. Packs LANES
//            activations per word (lane 0 in the LSBs), queues words in a
//            small FIFO and writes them to the output buffer at an
//            auto-incrementing address. A start pulse arms a frame of
//            frame_len activations; the final partial word is zero-padded.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            en, act_in, act_valid    - activation stream (no backpressure)
//            start, frame_len, base_addr - frame arm / configuration
//            wr_data, wr_addr, wr_en, wr_ready - buffer write handshake
//            busy, done, overflow     - status
//            checksum                 - only with HS_PACK_CHECKSUM_EN
// Macro    : HS_PACK_CHECKSUM_EN adds the signed running-sum checksum output.
// Revision : 1.0  initial release
// ============================================================================
module hs_out_packer
    import hs_pkg::*;
#(
    parameter int ACT_WIDTH  = c_ACT_WIDTH,
    parameter int LANES      = c_LANES,
    parameter int ADDR_WIDTH = 12,
    parameter int CNT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         start,
    input  logic [CNT_WIDTH-1:0]         frame_len,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    input  logic [ACT_WIDTH-1:0]         act_in,
    input  logic                         act_valid,
    output logic [LANES*ACT_WIDTH-1:0]   wr_data,
    output logic [ADDR_WIDTH-1:0]        wr_addr,
    output logic                         wr_en,
    input  logic                         wr_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow
`ifdef HS_PACK_CHECKSUM_EN
    ,
    output logic [ACT_WIDTH+3:0]         checksum
`endif
);

    localparam int c_WORD_W = LANES * ACT_WIDTH;
    localparam int c_LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    hs_state_t               r_state;
    hs_state_t               w_state_nxt;

    logic [c_LANE_W-1:0]     r_lane_cnt;
    logic [c_WORD_W-1:0]     r_lanes;
    logic [c_WORD_W-1:0]     w_lanes_ins;
    logic [c_WORD_W-1:0]     r_word;
    logic                    r_push;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [CNT_WIDTH-1:0]    r_len;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic                    r_overflow;

    logic                    w_start_ok;
    logic                    w_acc;
    logic                    w_drop_act;
    logic                    w_last_act;
    logic                    w_word_end;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_fifo_drop;
    logic [c_WORD_W-1:0]     w_head;

    assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_acc       = act_valid && en && (r_state == ST_PACK);
    assign w_drop_act  = act_valid && en && (r_state != ST_PACK);
    assign w_last_act  = (r_cnt == (r_len - CNT_WIDTH'(1)));
    assign w_word_end  = w_acc && ((r_lane_cnt == c_LANE_W'(LANES - 1)) || w_last_act);
    assign w_pop       = wr_en && wr_ready;
    assign w_fifo_drop = r_push && w_full && !w_pop;

    // Current lane register with the incoming activation dropped into its lane.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_lanes_ins[g*ACT_WIDTH +: ACT_WIDTH] =
            (r_lane_cnt == c_LANE_W'(g)) ? act_in : r_lanes[g*ACT_WIDTH +: ACT_WIDTH];
    end

    // ------------------------------------------------------------------
    // Frame control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = ST_PACK;
                end
            end
            ST_PACK: begin
                busy = 1'b1;
                if (w_acc && w_last_act) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                busy = 1'b1;
                // The staged final word must have reached the FIFO and drained.
                if (!r_push && w_empty) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = w_start_ok ? ST_PACK : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Packing datapath, address and sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane_cnt <= '0;
            r_lanes    <= '0;
            r_word     <= '0;
            r_push     <= 1'b0;
            r_cnt      <= '0;
            r_len      <= '0;
            r_wr_addr  <= '0;
            r_overflow <= 1'b0;
        end else begin
            // Completed words are staged one cycle before entering the FIFO.
            r_push <= w_word_end;
            if (w_word_end) begin
                r_word <= w_lanes_ins;
            end

            if (w_start_ok) begin
                r_len      <= (frame_len == '0) ? CNT_WIDTH'(1) : frame_len;
                r_cnt      <= '0;
                r_lane_cnt <= '0;
                r_lanes    <= '0;
                r_wr_addr  <= base_addr;
                r_overflow <= 1'b0;
            end else begin
                if (w_acc) begin
                    if (r_cnt != r_len) begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                    if (w_word_end) begin
                        r_lanes    <= '0;
                        r_lane_cnt <= '0;
                    end else begin
                        r_lanes    <= w_lanes_ins;
                        r_lane_cnt <= r_lane_cnt + c_LANE_W'(1);
                    end
                end
                if (w_pop) begin
                    r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);
                end
                if (w_drop_act || w_fifo_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    hs_word_fifo #(
        .WIDTH (c_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_push),
        .push_data (r_word),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign wr_en    = !w_empty;
    // Mask the head while empty so the bus never shows stale storage.
    assign wr_data  = w_empty ? '0 : w_head;
    assign wr_addr  = r_wr_addr;
    assign overflow = r_overflow;

`ifdef HS_PACK_CHECKSUM_EN
    logic signed [ACT_WIDTH+3:0] r_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
        end else if (w_start_ok) begin
            r_sum <= '0;
        end else if (w_acc) begin
            r_sum <= r_sum + $signed({{4{act_in[ACT_WIDTH-1]}}, act_in});
        end
    end

    assign checksum = r_sum;
`endif

endmodule : hs_out_packer
`default_nettype wire

// File: tb/tb_hs_out_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hs_out_packer
// Purpose  : Directed self-checking bench for hs_out_packer. Expected writes
//            are queued as stimulus is driven and compared as the DUT writes.
// Revision : 1.0  initial release
// ============================================================================
module tb_hs_out_packer;

    logic         clk;
    logic         rst;
    logic         en;
    logic         start;
    logic [15:0]  frame_len;
    logic [11:0]  base_addr;
    logic [13:0]  act_in;
    logic         act_valid;
    logic [55:0]  wr_data;
    logic [11:0]  wr_addr;
    logic         wr_en;
    logic         wr_ready;
    logic         busy;
    logic         done;
    logic         overflow;
`ifdef HS_PACK_CHECKSUM_EN
    logic [17:0]  checksum;
`endif

    int errors = 0;
    int checks = 0;
    int n_wr   = 0;
    int nwr_before;

    typedef struct packed {
        logic [11:0] a;
        logic [55:0] d;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    hs_out_packer dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .start     (start),
        .frame_len (frame_len),
        .base_addr (base_addr),
        .act_in    (act_in),
        .act_valid (act_valid),
        .wr_data   (wr_data),
        .wr_addr   (wr_addr),
        .wr_en     (wr_en),
        .wr_ready  (wr_ready),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
`ifdef HS_PACK_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [55:0] pk(input logic [13:0] a3, input logic [13:0] a2,
                                       input logic [13:0] a1, input logic [13:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    task automatic expect_wr(input logic [11:0] a, input logic [55:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic act(input logic [13:0] v);
        en        = 1'b1;
        act_in    = v;
        act_valid = 1'b1;
        cyc();
        act_valid = 1'b0;
    endtask

    task automatic start_frame(input logic [15:0] len, input logic [11:0] base);
        frame_len = len;
        base_addr = base;
        start     = 1'b1;
        cyc();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit sum_chk, input logic [17:0] sum_exp);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 60) begin
            cyc();
            k++;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
`ifdef HS_PACK_CHECKSUM_EN
        if (sum_chk) chk({tag, "_checksum"}, 64'(checksum), 64'(sum_exp));
`endif
        cyc();
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_busy_low"}, 64'(busy), 64'd0);
        chk({tag, "_queue_drained"}, 64'(q.size()), 64'd0);
`ifdef HS_PACK_CHECKSUM_EN
        if (sum_chk) chk({tag, "_checksum_held"}, 64'(checksum), 64'(sum_exp));
`endif
    endtask

    // Write monitor: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && wr_en && wr_ready) begin
            n_wr++;
            chk("wr_expected", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                mon_e = q.pop_front();
                chk("wr_addr", 64'(wr_addr), 64'(mon_e.a));
                chk("wr_data", 64'(wr_data), 64'(mon_e.d));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        start     = 1'b0;
        frame_len = 16'd0;
        base_addr = 12'd0;
        act_in    = 14'd0;
        act_valid = 1'b0;
        wr_ready  = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;

        // Reset state
        chk("rst_wr_en",    64'(wr_en),    64'd0);
        chk("rst_wr_addr",  64'(wr_addr),  64'd0);
        chk("rst_wr_data",  64'(wr_data),  64'd0);
        chk("rst_busy",     64'(busy),     64'd0);
        chk("rst_done",     64'(done),     64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        en = 1'b1;

        // Full frame, two words; an en=0 strobe in the middle must be ignored
        start_frame(16'd8, 12'h010);
        chk("t1_busy", 64'(busy), 64'd1);
        expect_wr(12'h010, pk(14'd4, 14'd3, 14'd2, 14'd1));
        expect_wr(12'h011, pk(14'd8, 14'd7, 14'd6, 14'd5));
        for (int i = 1; i <= 4; i++) act(14'(i));
        en = 1'b0; act_in = 14'h55; act_valid = 1'b1; cyc(); act_valid = 1'b0; en = 1'b1;
        for (int i = 5; i <= 8; i++) act(14'(i));
        wait_done("t1", 1'b1, 18'd36);
        chk("t1_overflow", 64'(overflow), 64'd0);

        // Partial final word is zero-padded
        start_frame(16'd5, 12'h020);
        expect_wr(12'h020, pk(14'd3, 14'd2, 14'd1, 14'h3FFF));
        expect_wr(12'h021, pk(14'd0, 14'd0, 14'd0, 14'h2000));
        act(14'h3FFF); act(14'd1); act(14'd2); act(14'd3); act(14'h2000);
        wait_done("t2", 1'b0, 18'd0);

        // frame_len 0 behaves as 1; address wraps past the top
        start_frame(16'd0, 12'hFFF);
        expect_wr(12'hFFF, pk(14'd0, 14'd0, 14'd0, 14'd7));
        act(14'd7);
        wait_done("t2b", 1'b1, 18'd7);
        chk("t2b_addr_wrap", 64'(wr_addr), 64'h000);

        // Activation while idle is dropped and flagged
        act(14'h11);
        chk("idle_act_overflow", 64'(overflow), 64'd1);

        // Backpressure: four words fit exactly, head held stable
        wr_ready = 1'b0;
        start_frame(16'd16, 12'h100);
        chk("t3_start_clears_ovf", 64'(overflow), 64'd0);
        for (int k = 0; k < 4; k++)
            expect_wr(12'h100 + 12'(k), pk(14'(16'h104 + 4*k), 14'(16'h103 + 4*k),
                                           14'(16'h102 + 4*k), 14'(16'h101 + 4*k)));
        for (int i = 1; i <= 16; i++) act(14'(16'h100 + i));
        repeat (2) cyc();
        for (int s = 0; s < 3; s++) begin
            chk("t3_stall_wr_en",   64'(wr_en),    64'd1);
            chk("t3_stall_wr_data", 64'(wr_data),  64'(pk(14'h104, 14'h103, 14'h102, 14'h101)));
            chk("t3_stall_wr_addr", 64'(wr_addr),  64'h100);
            chk("t3_stall_overflow", 64'(overflow), 64'd0);
            cyc();
        end
        wr_ready = 1'b1;
        wait_done("t3", 1'b0, 18'd0);

        // Overflow: six words into a four-entry FIFO under stall
        wr_ready = 1'b0;
        start_frame(16'd24, 12'h200);
        for (int k = 0; k < 4; k++)
            expect_wr(12'h200 + 12'(k), pk(14'(16'h204 + 4*k), 14'(16'h203 + 4*k),
                                           14'(16'h202 + 4*k), 14'(16'h201 + 4*k)));
        for (int i = 1; i <= 24; i++) act(14'(16'h200 + i));
        repeat (2) cyc();
        chk("t4_overflow", 64'(overflow), 64'd1);
        repeat (3) cyc();
        chk("t4_overflow_sticky", 64'(overflow), 64'd1);
        chk("t4_head_kept", 64'(wr_data), 64'(pk(14'h204, 14'h203, 14'h202, 14'h201)));
        wr_ready = 1'b1;
        wait_done("t4", 1'b0, 18'd0);
        chk("t4_overflow_after_done", 64'(overflow), 64'd1);

        // Reset mid-frame with a word queued: it must be discarded
        wr_ready = 1'b0;
        start_frame(16'd8, 12'h300);
        chk("t5_start_clears_ovf", 64'(overflow), 64'd0);
        act(14'd1); act(14'd2); act(14'd3); act(14'd4);
        cyc();
        chk("t5_queued_wr_en", 64'(wr_en), 64'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        wr_ready = 1'b1;
        chk("t5_rst_wr_en",   64'(wr_en),   64'd0);
        chk("t5_rst_busy",    64'(busy),    64'd0);
        chk("t5_rst_wr_addr", 64'(wr_addr), 64'd0);
        cyc();
        chk("t5_still_no_wr", 64'(wr_en),   64'd0);
        nwr_before = n_wr;
        start_frame(16'd4, 12'h040);
        expect_wr(12'h040, pk(14'd12, 14'd11, 14'd10, 14'd9));
        act(14'd9); act(14'd10); act(14'd11); act(14'd12);
        wait_done("t5", 1'b0, 18'd0);
        chk("t5_one_write", 64'(n_wr - nwr_before), 64'd1);

        // Signed activations; checksum -1018 when enabled
        start_frame(16'd4, 12'h050);
        expect_wr(12'h050, pk(14'h3FFE, 14'd5, 14'd3, 14'h3C00));
        act(14'h3C00); act(14'd3); act(14'd5); act(14'h3FFE);
        wait_done("t6", 1'b1, 18'h3FC06);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_hs_out_packer
`default_nettype wire
